// File: rtl/pixel_readout_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pixel_readout_pkg
// Purpose : Shared types and helpers for the pixel row readout path.
//           The line-entry struct is declared in the top level because its
//           widths follow the array-size parameters.
// Revision: 1.0  initial release
// ============================================================================
package pixel_readout_pkg;

  typedef logic [7:0] pix_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_line_fifo.sv
`default_nettype none
// ============================================================================
// Module  : pixel_line_fifo
// Purpose : Two-entry line buffer. A push into a full buffer is accepted
//           only when a pop happens in the same cycle (the pop frees the
//           slot first); otherwise the push is ignored.
// Ports   : clk, reset (async, active low)
//           push / push_data : write one entry
//           pop              : release the head entry
//           head             : current head entry
//           full / empty     : occupancy flags
// Revision: 1.0  initial release
// ============================================================================
module pixel_line_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [0:1];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_readout.sv
`default_nettype none
// ============================================================================
// Module  : pixel_readout
// Purpose : Captures the row driven on pixData while one bit of read is
//           set, commits it to a two-row line buffer when read drops, and
//           serializes buffered rows as a valid/ready byte stream with
//           row/column and frame markers.
// Ports   : clk, reset (async, active low)
//           read, pixData          : row-read bus from the array
//           out_valid/out_ready    : byte handshake
//           out_data/out_row/out_col, out_sof/out_eol/out_eof : byte + tags
//           overflow, sel_err      : sticky error flags
// Revision: 1.0  initial release
// ============================================================================
module pixel_readout
  import pixel_readout_pkg::*;
#(
  parameter int horizontal_pixels = 2,
  parameter int vertical_pixels   = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [vertical_pixels-1:0]          read,
  input  logic [0:horizontal_pixels-1][7:0]   pixData,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [7:0]                          out_data,
  output logic [idx_w(vertical_pixels)-1:0]   out_row,
  output logic [idx_w(horizontal_pixels)-1:0] out_col,
  output logic                                out_sof,
  output logic                                out_eol,
  output logic                                out_eof,
  output logic                                overflow,
  output logic                                sel_err
);

  localparam int RW = idx_w(vertical_pixels);
  localparam int CW = idx_w(horizontal_pixels);
  localparam logic [vertical_pixels-1:0] READ_ONE = 1;
  localparam logic [CW-1:0] LAST_COL = CW'(horizontal_pixels - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(vertical_pixels - 1);

  typedef struct packed {
    logic [RW-1:0]                  row;
    pix_t [0:horizontal_pixels-1]   words;
  } line_t;

  line_t          cap_line;
  logic           cap_active;
  logic [RW-1:0]  sel_row;
  logic           multi_hot;
  logic           commit;
  logic           accept;
  logic           last_col;
  logic           pop;
  logic           push_ok;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_one;
  logic [$bits(line_t)-1:0] head_bits;
  line_t          head;
  ser_state_t     state;
  logic [CW-1:0]  col;

  // Lowest set bit wins: scan from the top so the last hit is the lowest.
  always_comb begin
    sel_row = '0;
    for (int i = vertical_pixels - 1; i >= 0; i--) begin
      if (read[i]) sel_row = RW'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if read was multi-hot.
  assign multi_hot = |(read & (read - READ_ONE));
  assign commit    = cap_active && (read == '0);

  assign accept   = out_valid && out_ready;
  assign last_col = (col == LAST_COL);
  assign pop      = accept && last_col;
  assign push_ok  = commit && (!fifo_full || pop);
  assign fifo_one = !fifo_empty && !fifo_full;

  pixel_line_fifo #(
    .WIDTH($bits(line_t))
  ) u_line_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (commit),
    .push_data (cap_line),
    .pop       (pop),
    .head      (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head = line_t'(head_bits);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_line   <= '0;
      cap_active <= 1'b0;
      overflow   <= 1'b0;
      sel_err    <= 1'b0;
      state      <= IDLE;
      col        <= '0;
    end else begin
      cap_active <= |read;
      if (|read) begin
        cap_line.row   <= sel_row;
        cap_line.words <= pixData;
        if (multi_hot) sel_err <= 1'b1;
      end
      if (commit && !push_ok) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (push_ok) begin
            state <= SEND;
            col   <= '0;
          end
        end
        SEND: begin
          if (accept) begin
            if (last_col) begin
              col <= '0;
              // Stay in SEND when another entry remains after the pop.
              if (fifo_one && !push_ok) state <= IDLE;
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tags derive only from registered state, so they hold while stalled and
  // never see out_ready combinationally. Gating keeps them at 0 when idle.
  assign out_valid = (state == SEND);
  assign out_data  = out_valid ? head.words[col] : 8'h00;
  assign out_row   = out_valid ? head.row : '0;
  assign out_col   = out_valid ? col : '0;
  assign out_sof   = out_valid && (head.row == '0) && (col == '0);
  assign out_eol   = out_valid && last_col;
  assign out_eof   = out_valid && last_col && (head.row == LAST_ROW);

endmodule
`default_nettype wire

// File: tb/tb_pixel_readout.sv
`default_nettype none
// ============================================================================
// Module  : tb_pixel_readout
// Purpose : Self-checking bench for pixel_readout on a 2x2 array.
// Revision: 1.0  initial release
// ============================================================================
module tb_pixel_readout;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      read = 2'b00;
  logic [0:1][7:0] pixData = '0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [7:0]      out_data;
  logic [0:0]      out_row;
  logic [0:0]      out_col;
  logic            out_sof, out_eol, out_eof, overflow, sel_err;

  pixel_readout #(
    .horizontal_pixels(2),
    .vertical_pixels  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .read      (read),
    .pixData   (pixData),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .overflow  (overflow),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  // {data, row, col, sof, eol, eof}
  typedef logic [12:0] beat_t;
  beat_t exp_q[$];
  beat_t obs;
  beat_t held;
  beat_t popped;
  bit    stalled = 1'b0;
  bit    tog = 1'b0;
  int    tests = 0;
  int    fails = 0;

  assign obs = {out_data, out_row, out_col, out_sof, out_eol, out_eof};

  function automatic beat_t mk(input logic [7:0] d, input logic r, input logic c);
    return {d, r, c, (!r && !c), c, (r && c)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (tog) out_ready = ~out_ready;
  endtask

  task automatic push_exp(input logic r, input logic [7:0] w0, input logic [7:0] w1);
    exp_q.push_back(mk(w0, r, 1'b0));
    exp_q.push_back(mk(w1, r, 1'b1));
  endtask

  task automatic send_row(input logic r, input logic [7:0] w0, input logic [7:0] w1,
                          input int idle);
    read    = r ? 2'b10 : 2'b01;
    pixData = {w0, w1};
    step();
    read = 2'b00;
    repeat (idle) step();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    tog = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("drain_idle_valid", {31'd0, out_valid}, 0);
  endtask

  // Scoreboard consumer and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", {31'd0, out_valid}, 1);
        check("stall_beat", {19'd0, obs}, {19'd0, held});
      end
      if (out_valid && out_ready) begin
        tests++;
        assert (exp_q.size() > 0) else begin
          fails++;
          $error("FAIL extra_byte observed=%0h expected=none", obs);
        end
        if (exp_q.size() > 0) begin
          popped = exp_q.pop_front();
          check("stream_beat", {19'd0, obs}, {19'd0, popped});
        end
      end
      stalled = out_valid && !out_ready;
      held    = obs;
    end
  end

  initial begin
    // Reset state
    repeat (3) step();
    check("reset_outputs", {15'd0, out_valid, out_data, out_row, out_col,
                            out_sof, out_eol, out_eof, overflow, sel_err}, 0);
    reset = 1'b1;
    step();

    // Single row, one-cycle read, latency and markers
    out_ready = 1'b1;
    push_exp(1'b0, 8'h11, 8'h22);
    send_row(1'b0, 8'h11, 8'h22, 1);
    check("lat_col0", {19'd0, obs}, {19'd0, mk(8'h11, 1'b0, 1'b0)});
    check("lat_valid", {31'd0, out_valid}, 1);
    step();
    check("lat_col1", {19'd0, obs}, {19'd0, mk(8'h22, 1'b0, 1'b1)});
    step();
    check("lat_done", {31'd0, out_valid}, 0);

    // Full frame, eof only on last byte of row 1
    push_exp(1'b0, 8'hA0, 8'hA1);
    send_row(1'b0, 8'hA0, 8'hA1, 2);
    push_exp(1'b1, 8'hB0, 8'hB1);
    send_row(1'b1, 8'hB0, 8'hB1, 2);
    drain();

    // Commit into a full buffer while the head's last byte pops: no overflow
    out_ready = 1'b0;
    push_exp(1'b0, 8'h31, 8'h32);
    send_row(1'b0, 8'h31, 8'h32, 1);
    push_exp(1'b1, 8'h41, 8'h42);
    send_row(1'b1, 8'h41, 8'h42, 1);
    read = 2'b01;
    pixData = {8'h51, 8'h52};
    out_ready = 1'b1;
    push_exp(1'b0, 8'h51, 8'h52);
    step();
    read = 2'b00;
    step();
    check("pushpop_no_ovf", {31'd0, overflow}, 0);
    drain();

    // Three rows into a stalled stream: third dropped
    out_ready = 1'b0;
    push_exp(1'b0, 8'h61, 8'h62);
    send_row(1'b0, 8'h61, 8'h62, 1);
    push_exp(1'b1, 8'h71, 8'h72);
    send_row(1'b1, 8'h71, 8'h72, 1);
    send_row(1'b0, 8'h81, 8'h82, 1);
    check("ovf_flag", {31'd0, overflow}, 1);
    check("ovf_head", {24'd0, out_data}, 32'h61);
    out_ready = 1'b1;
    drain();

    // Ready toggling every cycle
    out_ready = 1'b1;
    tog = 1'b1;
    push_exp(1'b0, 8'hC3, 8'hC4);
    send_row(1'b0, 8'hC3, 8'hC4, 2);
    push_exp(1'b1, 8'hD5, 8'hD6);
    send_row(1'b1, 8'hD5, 8'hD6, 2);
    drain();

    // Multi-hot select
    check("selerr_before", {31'd0, sel_err}, 0);
    read = 2'b11;
    pixData = {8'h55, 8'h66};
    push_exp(1'b0, 8'h55, 8'h66);
    step();
    read = 2'b00;
    step();
    check("selerr_flag", {31'd0, sel_err}, 1);
    check("selerr_row", {31'd0, out_row}, 0);
    drain();

    // Asynchronous reset in the middle of a row being sent
    out_ready = 1'b0;
    send_row(1'b0, 8'hE0, 8'hE1, 1);
    check("rst_pre_valid", {31'd0, out_valid}, 1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_outputs", {15'd0, out_valid, out_data, out_row, out_col,
                                out_sof, out_eol, out_eof, overflow, sel_err}, 0);
    exp_q.delete();
    step();
    reset = 1'b1;
    step();
    check("rst_post_idle", {31'd0, out_valid}, 0);
    out_ready = 1'b1;
    push_exp(1'b1, 8'hF0, 8'hF1);
    send_row(1'b1, 8'hF0, 8'hF1, 1);
    check("rst_restart", {22'd0, out_valid, out_col, out_data}, {22'd0, 1'b1, 1'b0, 8'hF0});
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
